// File: rtl/matrix_op_dispatcher.sv
// Matrix op dispatcher: latches a selection, reads A's header, launches the engine.
// Optional watchdog in RUN: define MATRIX_OP_DISPATCHER_WATCHDOG_EN.
package matrix_op_selector_pkg;
  typedef enum logic [2:0] {
    CALC_ADD   = 3'd0,
    CALC_SUB   = 3'd1,
    CALC_MUL   = 3'd2,
    CALC_SCALE = 3'd3,
    CALC_TRANS = 3'd4
  } calc_type_t;
endpackage

module matrix_op_dispatcher
  import matrix_op_selector_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE     = 1152,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned RESULT_ID      = 7,
  parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel_valid,
  input  calc_type_t            sel_op,
  input  logic [2:0]            sel_matrix_a,
  input  logic [2:0]            sel_matrix_b,
  input  logic [31:0]           sel_scalar,
  output logic                  busy,
  output logic                  sel_dropped,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [31:0]           bram_data,
  output logic                  eng_start,
  output calc_type_t            eng_op,
  output logic [ADDR_WIDTH-1:0] eng_addr_a,
  output logic [ADDR_WIDTH-1:0] eng_addr_b,
  output logic [ADDR_WIDTH-1:0] eng_addr_c,
  output logic [7:0]            eng_rows,
  output logic [7:0]            eng_cols,
  output logic [31:0]           eng_scalar,
  input  logic                  eng_done,
  input  logic                  eng_error,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code,
  output logic [2:0]            result_id
);

  localparam logic [2:0] RID = RESULT_ID[2:0];
  localparam logic [ADDR_WIDTH-1:0] BASE_C =
    ADDR_WIDTH'(RESULT_ID * BLOCK_SIZE);

  typedef enum logic [2:0] {
    IDLE, RD_HDR, WAIT_HDR, CHECK,
    LAUNCH, RUN, FINISH, FAIL
  } state_t;

  state_t state, next;

  calc_type_t op_q;
  logic [2:0] a_q, b_q;
  logic [31:0] scalar_q;
  logic [7:0] rows_q, cols_q;
  logic [ADDR_WIDTH-1:0] addr_c_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0] err_q;
  logic [2:0] fail_code;
  logic accept;
  logic wd_hit;
  logic [15:0] unused_hdr;

  function automatic logic [ADDR_WIDTH-1:0] base(
    input logic [2:0] id
  );
    logic [31:0] p;
    p = 32'(id) * 32'(BLOCK_SIZE);
    return p[ADDR_WIDTH-1:0];
  endfunction

  assign unused_hdr = bram_data[31:16];
  assign accept = (state == IDLE) && sel_valid;

`ifdef MATRIX_OP_DISPATCHER_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  // Watchdog: cycles spent in RUN, restarted on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == RUN) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_wd
    end
  endgenerate
  assign wd_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state logic and failure classification.
  always_comb begin
    next      = state;
    fail_code = 3'd0;
    case (state)
      IDLE:     if (sel_valid) next = RD_HDR;
      RD_HDR:   next = WAIT_HDR;
      WAIT_HDR: next = CHECK;
      CHECK: begin
        if (rows_q == 8'd0 || cols_q == 8'd0) begin
          next      = FAIL;
          fail_code = 3'd1;
        end else if (a_q == RID ||
                     (b_q == RID && op_q == CALC_MUL)) begin
          next      = FAIL;
          fail_code = 3'd2;
        end else begin
          next = LAUNCH;
        end
      end
      LAUNCH: next = RUN;
      RUN: begin
        if (eng_error) begin
          next      = FAIL;
          fail_code = 3'd4;
        end else if (eng_done) begin
          next = FINISH;
        end else if (wd_hit) begin
          next      = FAIL;
          fail_code = 3'd3;
        end
      end
      FINISH:  next = IDLE;
      FAIL:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Selection latch, header capture, BRAM address and error code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= CALC_ADD;
      a_q      <= '0;
      b_q      <= '0;
      scalar_q <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      addr_c_q <= '0;
      addr_q   <= '0;
      err_q    <= '0;
    end else begin
      if (accept) begin
        op_q     <= sel_op;
        a_q      <= sel_matrix_a;
        b_q      <= sel_matrix_b;
        scalar_q <= sel_scalar;
        addr_c_q <= BASE_C;
        addr_q   <= base(sel_matrix_a);
        err_q    <= '0;
      end else if (next == FAIL || next == IDLE) begin
        addr_q <= '0;
      end
      if (state == WAIT_HDR) begin
        rows_q <= bram_data[7:0];
        cols_q <= bram_data[15:8];
      end
      if (next == FAIL && state != FAIL) begin
        err_q <= fail_code;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign sel_dropped = sel_valid && (state != IDLE);
  assign bram_addr   = addr_q;
  assign eng_start   = (state == LAUNCH);
  assign eng_op      = op_q;
  assign eng_addr_a  = base(a_q);
  assign eng_addr_b  = base(b_q);
  assign eng_addr_c  = addr_c_q;
  assign eng_rows    = rows_q;
  assign eng_cols    = cols_q;
  assign eng_scalar  = scalar_q;
  assign done        = (state == FINISH);
  assign error       = (state == FAIL);
  assign err_code    = err_q;
  assign result_id   = RID;

endmodule

// File: tb/tb_matrix_op_dispatcher.sv
// Scoreboard bench for matrix_op_dispatcher.
// Expectations are queued at issue; a negedge monitor pops and compares.
module tb_matrix_op_dispatcher;
  import matrix_op_selector_pkg::*;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel_valid = 1'b0;
  calc_type_t sel_op = CALC_ADD;
  logic [2:0] sel_matrix_a = '0;
  logic [2:0] sel_matrix_b = '0;
  logic [31:0] sel_scalar = '0;
  logic busy, sel_dropped;
  logic [AW-1:0] bram_addr;
  logic [31:0] bram_data = '0;
  logic eng_start;
  calc_type_t eng_op;
  logic [AW-1:0] eng_addr_a, eng_addr_b, eng_addr_c;
  logic [7:0] eng_rows, eng_cols;
  logic [31:0] eng_scalar;
  logic eng_done = 1'b0;
  logic eng_error = 1'b0;
  logic done, error;
  logic [2:0] err_code, result_id;

  matrix_op_dispatcher #(
    .BLOCK_SIZE(1152),
    .ADDR_WIDTH(AW),
    .RESULT_ID(7),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sel_valid(sel_valid), .sel_op(sel_op),
    .sel_matrix_a(sel_matrix_a), .sel_matrix_b(sel_matrix_b),
    .sel_scalar(sel_scalar),
    .busy(busy), .sel_dropped(sel_dropped),
    .bram_addr(bram_addr), .bram_data(bram_data),
    .eng_start(eng_start), .eng_op(eng_op),
    .eng_addr_a(eng_addr_a), .eng_addr_b(eng_addr_b),
    .eng_addr_c(eng_addr_c),
    .eng_rows(eng_rows), .eng_cols(eng_cols),
    .eng_scalar(eng_scalar),
    .eng_done(eng_done), .eng_error(eng_error),
    .done(done), .error(error),
    .err_code(err_code), .result_id(result_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [31:0] mem [0:16383];
  always @(posedge clk) bram_data <= mem[bram_addr];

  typedef struct {
    calc_type_t op;
    int a, b, c, rows, cols;
    logic [31:0] scalar;
    int cyc;
  } start_t;

  typedef struct {
    bit is_err;
    int code;
    int cyc;
  } cmpl_t;

  start_t start_q[$];
  cmpl_t  cmpl_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every engine launch and completion to the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_start) begin
        chk("start_expected", start_q.size() > 0, 1);
        if (start_q.size() > 0) begin
          start_t s;
          s = start_q.pop_front();
          chk("start_cycle", cyc, s.cyc);
          chk("eng_op", eng_op, s.op);
          chk("eng_addr_a", eng_addr_a, s.a);
          chk("eng_addr_b", eng_addr_b, s.b);
          chk("eng_addr_c", eng_addr_c, s.c);
          chk("eng_rows", eng_rows, s.rows);
          chk("eng_cols", eng_cols, s.cols);
          chk("eng_scalar", eng_scalar, s.scalar);
        end
      end
      if (done || error) begin
        chk("cmpl_expected", cmpl_q.size() > 0, 1);
        chk("done_error_excl", done && error, 0);
        if (cmpl_q.size() > 0) begin
          cmpl_t e;
          e = cmpl_q.pop_front();
          chk("cmpl_cycle", cyc, e.cyc);
          chk("cmpl_is_error", error, e.is_err);
          if (e.is_err) chk("err_code", err_code, e.code);
          else chk("result_id", result_id, 7);
        end
      end
    end
  end

  task automatic issue(input calc_type_t op, input int a,
                       input int b, input logic [31:0] sc,
                       output int c0);
    @(posedge clk); #1;
    sel_op = op;
    sel_matrix_a = 3'(a);
    sel_matrix_b = 3'(b);
    sel_scalar = sc;
    sel_valid = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    sel_valid = 1'b0;
  endtask

  task automatic exp_start(input calc_type_t op, input int a,
                           input int b, input int r, input int c,
                           input logic [31:0] sc, input int at);
    start_t s;
    s.op = op; s.a = a * 1152; s.b = b * 1152; s.c = 8064;
    s.rows = r; s.cols = c; s.scalar = sc; s.cyc = at;
    start_q.push_back(s);
  endtask

  task automatic exp_cmpl(input bit is_err, input int code,
                          input int at);
    cmpl_t e;
    e.is_err = is_err; e.code = code; e.cyc = at;
    cmpl_q.push_back(e);
  endtask

  task automatic wait_start();
    int n = 0;
    @(negedge clk);
    while (!eng_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_start_timeout", n < 100, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", n < 2000, 1);
  endtask

  // Engine response: done and/or error for one cycle.
  task automatic engine(input bit d, input bit e, input int after);
    int c;
    repeat (after) @(posedge clk);
    #1;
    eng_done = d;
    eng_error = e;
    c = cyc;
    if (e) exp_cmpl(1'b1, 4, c + 1);
    else if (d) exp_cmpl(1'b0, 0, c + 1);
    @(posedge clk); #1;
    eng_done = 1'b0;
    eng_error = 1'b0;
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    mem[0 * 1152] = 32'h0000_0404;
    mem[1 * 1152] = 32'h0000_0000;
    mem[2 * 1152] = 32'h0000_0303;
    mem[3 * 1152] = 32'hABCD_0506;
    mem[5 * 1152] = 32'h0000_0303;
    mem[7 * 1152] = 32'h0000_0202;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_result_id", result_id, 7);
    chk("rst_eng_addr_c", eng_addr_c, 0);
    chk("rst_err_code", err_code, 0);
    rst_n = 1'b1;

    // Happy path.
    issue(CALC_MUL, 2, 5, 32'h1234_5678, c0);
    exp_start(CALC_MUL, 2, 5, 3, 3, 32'h1234_5678, c0 + 4);
    @(negedge clk);
    chk("rd_hdr_bram_addr", bram_addr, 2304);
    chk("rd_hdr_busy", busy, 1);
    wait_start();
    engine(1'b1, 1'b0, 10);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);

    // Empty header.
    issue(CALC_ADD, 1, 2, 32'd0, c0);
    exp_cmpl(1'b1, 1, c0 + 4);
    wait_idle();
    chk("err_code_held", err_code, 1);
    chk("bram_addr_idle", bram_addr, 0);

    // Alias on A; err_code clears on accept.
    issue(CALC_ADD, 7, 2, 32'd0, c0);
    exp_cmpl(1'b1, 2, c0 + 4);
    @(negedge clk);
    chk("err_code_cleared", err_code, 0);
    wait_idle();

    // Alias on B for multiply.
    issue(CALC_MUL, 0, 7, 32'd0, c0);
    exp_cmpl(1'b1, 2, c0 + 4);
    wait_idle();

    // B == RESULT_ID is fine for a non-multiply op.
    issue(CALC_ADD, 0, 7, 32'd9, c0);
    exp_start(CALC_ADD, 0, 7, 4, 4, 32'd9, c0 + 4);
    wait_start();
    engine(1'b1, 1'b0, 2);
    wait_idle();

    // Header upper bits ignored.
    issue(CALC_TRANS, 3, 0, 32'hFFFF_FFFF, c0);
    exp_start(CALC_TRANS, 3, 0, 6, 5, 32'hFFFF_FFFF, c0 + 4);
    wait_start();
    engine(1'b1, 1'b0, 1);
    wait_idle();

    // Busy drop, then done+error together.
    issue(CALC_MUL, 2, 5, 32'd3, c0);
    exp_start(CALC_MUL, 2, 5, 3, 3, 32'd3, c0 + 4);
    wait_start();
    @(posedge clk); #1;
    sel_matrix_a = 3'd3;
    sel_matrix_b = 3'd1;
    sel_valid = 1'b1;
    @(negedge clk);
    chk("sel_dropped", sel_dropped, 1);
    @(posedge clk); #1;
    sel_valid = 1'b0;
    @(negedge clk);
    chk("dropped_addr_a", eng_addr_a, 2304);
    chk("dropped_addr_b", eng_addr_b, 5760);
    chk("sel_dropped_low", sel_dropped, 0);
    engine(1'b1, 1'b1, 2);
    wait_idle();

    // Engine strobes while idle are ignored.
    @(posedge clk); #1;
    eng_done = 1'b1;
    eng_error = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    eng_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_strobe_busy", busy, 0);

`ifdef MATRIX_OP_DISPATCHER_WATCHDOG_EN
    issue(CALC_MUL, 2, 5, 32'd0, c0);
    exp_start(CALC_MUL, 2, 5, 3, 3, 32'd0, c0 + 4);
    exp_cmpl(1'b1, 3, c0 + 55);
    wait_idle();
`else
    issue(CALC_MUL, 2, 5, 32'd0, c0);
    exp_start(CALC_MUL, 2, 5, 3, 3, 32'd0, c0 + 4);
    repeat (1000) @(negedge clk);
    chk("no_watchdog_busy", busy, 1);
    engine(1'b1, 1'b0, 0);
    wait_idle();
`endif

    // Reset mid-run, then a fresh selection.
    issue(CALC_SUB, 2, 5, 32'd4, c0);
    exp_start(CALC_SUB, 2, 5, 3, 3, 32'd4, c0 + 4);
    wait_start();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_eng_start", eng_start, 0);
    chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    chk("arst_bram_addr", bram_addr, 0);
    chk("arst_eng_addr_a", eng_addr_a, 0);
    chk("arst_eng_addr_c", eng_addr_c, 0);
    chk("arst_eng_rows", eng_rows, 0);
    chk("arst_result_id", result_id, 7);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(CALC_MUL, 2, 5, 32'd5, c0);
    exp_start(CALC_MUL, 2, 5, 3, 3, 32'd5, c0 + 4);
    wait_start();
    engine(1'b1, 1'b0, 4);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("start_q_drained", start_q.size(), 0);
    chk("cmpl_q_drained", cmpl_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
